key_expansion: RTL and testbench
================================

Name: key_expansion

Overview:
Iterative AES-128 key schedule. Loads a 128-bit cipher key and produces the 11 round keys (round 0 to 10) one at a time under a valid/next handshake. Each next round key is computed in one cycle with a single subWord instance (4 S-boxes). Sits upstream of the round datapath; the cipher core consumes RoundKey_DO.

Parameters:
None. AES-128 is fixed at 10 rounds, given by the package constant NUM_ROUNDS = 10.

Ports:
Clk_CI  in  1  clock; all state updates on the rising edge
Reset_RBI  in  1  synchronous active-low reset
Start_SI  in  1  load Key_DI; accepted only when Ready_SO=1
Key_DI  in  128  cipher key, FIPS-197 byte order (byte 0 = bits 127:120)
Ready_SO  out  1  block is idle and can accept Start_SI
Next_SI  in  1  consumer took the current round key; advance
RoundKey_DO  out  128  current round key, FIPS-197 byte order
RoundKeyValid_SO  out  1  RoundKey_DO / RoundIdx_DO are valid
RoundIdx_DO  out  4  index of the current round key, 0 to 10
LastKey_SO  out  1  RoundKeyValid_SO & (RoundIdx_DO == 10), combinational

Behaviour:
- Reset (Reset_RBI=0 at an edge):
  - state -> IDLE; key register, round counter and Rcon register cleared (Rcon = 0x01).
  - Outputs: Ready_SO=1, RoundKeyValid_SO=0, RoundKey_DO=0, RoundIdx_DO=0, LastKey_SO=0.
  - Reset mid-expansion aborts with no further output.
- States:
  - IDLE: Ready_SO=1, valid=0. If Start_SI=1: key register <- Key_DI, round <- 0, Rcon <- 0x01, go to RUN. Next_SI is ignored in IDLE.
  - RUN: Ready_SO=0, valid=1, RoundKey_DO = key register (registered output, no combinational path from inputs).
    - Next_SI=0: hold all state; key and index stay stable.
    - Next_SI=1 and round<10: key register <- f(key register), round <- round+1, Rcon <- xtime(Rcon).
    - Next_SI=1 and round==10: go to IDLE; valid=0 on the next cycle.
    - Start_SI is ignored in RUN.
- Latency:
  - Start accepted at edge t -> round 0 key valid after edge t (visible cycle t+1).
  - Each accepted Next_SI -> new key valid the following cycle.
  - Back-to-back Next_SI gives one key per cycle, 11 cycles total.
- Next-key function f, with w0..w3 = current key words (w0 = bits 127:96):
  - temp = SubWord(RotWord(w3)) XOR {Rcon, 00, 00, 00}
  - RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0)
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Rcon:
  - Sequence 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = (x<<1) XOR (x[7] ? 0x1b : 0x00), 8-bit result.
- Simultaneous events:
  - Start_SI and Next_SI together in IDLE: Start wins, Next ignored.
  - The cycle after the final Next_SI, the block is IDLE and accepts Start_SI.
- Key_DI is sampled only at the accepting edge; later changes have no effect.

Decomposition:
- aes128Pkg additions:
  - NUM_ROUNDS = 10
  - RCON_INIT = 8'h01
  - function xtime(Byte)
  - typedef Key128 as an array of 4 Words, with a key_expansion state enum {IDLE, RUN}.
  - Reuses the existing Byte and Word typedefs.
- Sub-module: one existing subWord instance, fed RotWord(w3). No other sub-modules; FSM, counter and XOR chain are local.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, Next_SI held 1 -> checked keys:
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 2 = f2c295f27a96b9435935807a7359f67f
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - LastKey_SO=1 only at index 10; Ready_SO=1 the cycle after.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Stall: Next_SI=0 for 5 cycles at round 3 (A.1 key) -> RoundKey_DO and RoundIdx_DO=3 stable. Then Next_SI=1 gives the correct round 4 key, 3d80477d4716fe3e1e237e446d7a883b.
- Start_SI pulsed with a different key during RUN -> ignored; the A.1 sequence completes unchanged.
- Reset_RBI=0 for one cycle at round 5 -> next cycle: valid=0, Ready_SO=1, RoundIdx_DO=0. A new Start yields a correct round 0 and round 1.
- Start_SI and Next_SI together in IDLE -> round 0 key presented and held; index does not skip to 1.

Source files
------------

// File: rtl/aes128Pkg.sv
// aes128Pkg: shared AES-128 types, key-schedule constants and GF(2^8) helpers.
// Revision 1.0
`default_nettype none

package aes128Pkg;

  typedef logic [7:0]  Byte;
  typedef logic [31:0] Word;

  // Word [3] holds w0 (bits 127:96) so the packed key keeps FIPS-197 byte order.
  typedef Word [3:0] Key128;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  localparam Byte        RCON_INIT  = 8'h01;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } kexpState_e;

  function automatic Byte xtime(input Byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/subWord.sv
// subWord: four parallel AES S-box lookups on one 32-bit word.
// Revision 1.0
`default_nettype none

module subWord
  import aes128Pkg::*;
(
  input  logic [31:0] Word_DI,
  output logic [31:0] Word_DO
);

  localparam Byte SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign Word_DO[8*i +: 8] = SBOX[Word_DI[8*i +: 8]];
  end

endmodule

`default_nettype wire

// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule, one round key per accepted Next_SI.
// Revision 1.0
`default_nettype none

module key_expansion
  import aes128Pkg::*;
(
  input  logic         Clk_CI,
  input  logic         Reset_RBI,
  input  logic         Start_SI,
  input  logic [127:0] Key_DI,
  output logic         Ready_SO,
  input  logic         Next_SI,
  output logic [127:0] RoundKey_DO,
  output logic         RoundKeyValid_SO,
  output logic [3:0]   RoundIdx_DO,
  output logic         LastKey_SO
);

  kexpState_e state_q;
  Key128      key_q;
  Key128      key_d;
  logic [3:0] round_q;
  Byte        rcon_q;
  logic       ready_q;
  logic       valid_q;

  logic [31:0] rotW3;
  logic [31:0] subW3;
  logic [31:0] temp;

  // key_q[0] is w3; RotWord moves its leading byte to the end.
  assign rotW3 = {key_q[0][23:0], key_q[0][31:24]};

  subWord u_subWord (
    .Word_DI (rotW3),
    .Word_DO (subW3)
  );

  assign temp = subW3 ^ {rcon_q, 24'h000000};

  always_comb begin
    key_d    = key_q;
    key_d[3] = key_q[3] ^ temp;
    key_d[2] = key_q[2] ^ key_d[3];
    key_d[1] = key_q[1] ^ key_d[2];
    key_d[0] = key_q[0] ^ key_d[1];
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start_SI) begin
            key_q   <= Key_DI;
            round_q <= 4'd0;
            rcon_q  <= RCON_INIT;
            state_q <= RUN;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (Next_SI) begin
            if (round_q == NUM_ROUNDS) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              key_q   <= key_d;
              round_q <= round_q + 4'd1;
              rcon_q  <= xtime(rcon_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Ready_SO         = ready_q;
  assign RoundKeyValid_SO = valid_q;
  assign RoundKey_DO      = key_q;
  assign RoundIdx_DO      = round_q;
  assign LastKey_SO       = valid_q & (round_q == NUM_ROUNDS);

endmodule

`default_nettype wire

// File: tb/tb_key_expansion.sv
// tb_key_expansion: scoreboard bench for the AES-128 key schedule.
// Revision 1.0
`default_nettype none

module tb_key_expansion;

  logic         clk;
  logic         Reset_RBI;
  logic         Start_SI;
  logic [127:0] Key_DI;
  logic         Ready_SO;
  logic         Next_SI;
  logic [127:0] RoundKey_DO;
  logic         RoundKeyValid_SO;
  logic [3:0]   RoundIdx_DO;
  logic         LastKey_SO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t sb [$];

  localparam logic [127:0] A1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  key_expansion dut (
    .Clk_CI           (clk),
    .Reset_RBI        (Reset_RBI),
    .Start_SI         (Start_SI),
    .Key_DI           (Key_DI),
    .Ready_SO         (Ready_SO),
    .Next_SI          (Next_SI),
    .RoundKey_DO      (RoundKey_DO),
    .RoundKeyValid_SO (RoundKeyValid_SO),
    .RoundIdx_DO      (RoundIdx_DO),
    .LastKey_SO       (LastKey_SO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_a1();
    for (int r = 0; r <= 10; r++) sb.push_back('{idx: 4'(r), key: A1[r], chk: 1'b1});
  endtask

  task automatic start_key(input logic [127:0] k);
    for (int i = 0; i < 20 && !Ready_SO; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (Ready_SO !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: Ready_SO=%b required 1", Ready_SO);
    end
    Start_SI = 1'b1;
    Key_DI   = k;
    @(posedge clk); #1;
    Start_SI = 1'b0;
    Key_DI   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Walks the queued keys, optionally stalling at one index or pulsing Start at another.
  task automatic consume(input int stall_idx, input int stall_cycles, input int pulse_idx);
    exp_t e;
    logic [127:0] held;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (RoundKeyValid_SO !== 1'b1) begin
        errors++;
        $display("FAIL valid r%0d: got %b required 1", e.idx, RoundKeyValid_SO);
      end
      checks++;
      if (RoundIdx_DO !== e.idx) begin
        errors++;
        $display("FAIL index: got %0d required %0d", RoundIdx_DO, e.idx);
      end
      if (e.chk) begin
        checks++;
        if (RoundKey_DO !== e.key) begin
          errors++;
          $display("FAIL key r%0d: got %h required %h", e.idx, RoundKey_DO, e.key);
        end
      end
      checks++;
      if (LastKey_SO !== (e.idx == 4'd10)) begin
        errors++;
        $display("FAIL last r%0d: got %b required %b", e.idx, LastKey_SO, (e.idx == 4'd10));
      end
      if (int'(e.idx) == stall_idx) begin
        held    = RoundKey_DO;
        Next_SI = 1'b0;
        repeat (stall_cycles) begin
          @(posedge clk); #1;
          checks++;
          if (RoundIdx_DO !== e.idx || RoundKey_DO !== held || RoundKeyValid_SO !== 1'b1) begin
            errors++;
            $display("FAIL stall: got idx %0d key %h required idx %0d key %h", RoundIdx_DO, RoundKey_DO, e.idx, held);
          end
        end
      end
      Next_SI = 1'b1;
      if (int'(e.idx) == pulse_idx) begin
        Start_SI = 1'b1;
        Key_DI   = 128'h000102030405060708090a0b0c0d0e0f;
      end
      @(posedge clk); #1;
      Start_SI = 1'b0;
    end
    Next_SI = 1'b0;
    checks++;
    if (RoundKeyValid_SO !== 1'b0 || Ready_SO !== 1'b1 || LastKey_SO !== 1'b0) begin
      errors++;
      $display("FAIL done: got valid %b ready %b last %b required 0 1 0", RoundKeyValid_SO, Ready_SO, LastKey_SO);
    end
  endtask

  task automatic test_reset();
    Reset_RBI = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Ready_SO !== 1'b1 || RoundKeyValid_SO !== 1'b0 || RoundKey_DO !== 128'h0 ||
        RoundIdx_DO !== 4'd0 || LastKey_SO !== 1'b0) begin
      errors++;
      $display("FAIL reset: got ready %b valid %b key %h idx %0d last %b required 1 0 0 0 0",
               Ready_SO, RoundKeyValid_SO, RoundKey_DO, RoundIdx_DO, LastKey_SO);
    end
    Reset_RBI = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    start_key(A1[0]);
    push_a1();
    consume(-1, 0, -1);
  endtask

  task automatic test_zero_key();
    start_key(128'h0);
    for (int r = 0; r <= 10; r++) begin
      case (r)
        0:       sb.push_back('{idx: 4'(r), key: 128'h0, chk: 1'b1});
        1:       sb.push_back('{idx: 4'(r), key: 128'h62636363626363636263636362636363, chk: 1'b1});
        10:      sb.push_back('{idx: 4'(r), key: 128'hb4ef5bcb3e92e21123e951cf6f8f188e, chk: 1'b1});
        default: sb.push_back('{idx: 4'(r), key: 128'h0, chk: 1'b0});
      endcase
    end
    consume(-1, 0, -1);
  endtask

  task automatic test_stall();
    start_key(A1[0]);
    push_a1();
    consume(3, 5, -1);
  endtask

  task automatic test_start_in_run();
    start_key(A1[0]);
    push_a1();
    consume(-1, 0, 4);
  endtask

  task automatic test_reset_mid();
    start_key(A1[0]);
    for (int r = 0; r <= 5; r++) sb.push_back('{idx: 4'(r), key: A1[r], chk: 1'b1});
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (RoundIdx_DO !== e.idx || RoundKey_DO !== e.key) begin
        errors++;
        $display("FAIL pre_reset r%0d: got idx %0d key %h required %h", e.idx, RoundIdx_DO, RoundKey_DO, e.key);
      end
      if (sb.size() > 0) begin
        Next_SI = 1'b1;
        @(posedge clk); #1;
      end
    end
    Next_SI   = 1'b0;
    Reset_RBI = 1'b0;
    @(posedge clk); #1;
    Reset_RBI = 1'b1;
    checks++;
    if (RoundKeyValid_SO !== 1'b0 || Ready_SO !== 1'b1 || RoundIdx_DO !== 4'd0 || LastKey_SO !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid %b ready %b idx %0d last %b required 0 1 0 0",
               RoundKeyValid_SO, Ready_SO, RoundIdx_DO, LastKey_SO);
    end
    @(posedge clk); #1;
    checks++;
    if (RoundKeyValid_SO !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got valid %b required 0", RoundKeyValid_SO);
    end
    start_key(A1[0]);
    push_a1();
    consume(-1, 0, -1);
  endtask

  task automatic test_start_next_idle();
    Start_SI = 1'b1;
    Next_SI  = 1'b1;
    Key_DI   = A1[0];
    @(posedge clk); #1;
    Start_SI = 1'b0;
    Next_SI  = 1'b0;
    Key_DI   = '0;
    repeat (2) begin
      checks++;
      if (RoundIdx_DO !== 4'd0 || RoundKey_DO !== A1[0] || RoundKeyValid_SO !== 1'b1) begin
        errors++;
        $display("FAIL start_next: got idx %0d key %h valid %b required 0 %h 1",
                 RoundIdx_DO, RoundKey_DO, RoundKeyValid_SO, A1[0]);
      end
      @(posedge clk); #1;
    end
    push_a1();
    consume(-1, 0, -1);
  endtask

  initial begin
    Reset_RBI = 1'b0;
    Start_SI  = 1'b0;
    Next_SI   = 1'b0;
    Key_DI    = '0;
    test_reset();
    test_fips();
    test_zero_key();
    test_stall();
    test_start_in_run();
    test_reset_mid();
    test_start_next_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
